// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, counter type and receiver FSM states.
// Used by both the sync receiver and the VGA generator.
package vga_timing_pkg;

  localparam int CNT_W = 12;

  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_TOTAL  = 800;

  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_TOTAL  = 525;

  localparam int VGA_LOCK_FRAMES = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } sync_state_e;

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/sync_fall_detect.sv
// Falling-edge detector for an active-low sync line.
// History only advances when i_en is high, so the line can be sampled on a strobe.
module sync_fall_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_sync,
  output logic o_fall
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = i_en ? i_sync : prev_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) prev_q <= 1'b1;
    else       prev_q <= prev_d;
  end

  assign o_fall = i_en & prev_q & ~i_sync;

endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates from HSync/VSync and tracks lock to the
// expected line/frame timing.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC_WIDTH = VGA_H_SYNC,
  parameter int H_BACK_PORCH = VGA_H_BP,
  parameter int WIDTH        = VGA_H_ACTIVE,
  parameter int H_TOTAL      = VGA_H_TOTAL,
  parameter int V_SYNC_WIDTH = VGA_V_SYNC,
  parameter int V_BACK_PORCH = VGA_V_BP,
  parameter int HEIGHT       = VGA_V_ACTIVE,
  parameter int V_TOTAL      = VGA_V_TOTAL,
  parameter int LOCK_FRAMES  = VGA_LOCK_FRAMES
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_HSync,
  input  logic        i_VSync,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_valid,
  output logic        o_locked,
  output logic        o_frame_start,
  output logic        o_error
);

  localparam cnt_t H_LO   = cnt_t'(H_SYNC_WIDTH + H_BACK_PORCH);
  localparam cnt_t H_HI   = cnt_t'(H_SYNC_WIDTH + H_BACK_PORCH + WIDTH);
  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t H_END  = cnt_t'(H_TOTAL);
  localparam cnt_t V_LO   = cnt_t'(V_SYNC_WIDTH + V_BACK_PORCH);
  localparam cnt_t V_HI   = cnt_t'(V_SYNC_WIDTH + V_BACK_PORCH + HEIGHT);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t V_END  = cnt_t'(V_TOTAL);
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

  logic        hfe;
  logic        vfe;
  cnt_t        h_q, h_d;
  cnt_t        v_q, v_d;
  logic        line_err;
  logic        frame_err;
  logic        err;
  logic        h_act;
  logic        v_act;
  logic        valid_q, valid_d;
  cnt_t        x_q, x_d;
  cnt_t        y_q, y_d;
  logic        fs_q, fs_d;
  logic        err_q;
  logic [7:0]  good_q;
  sync_state_e state_q;

  sync_fall_detect u_hs (
    .i_clk  (i_Clk),
    .i_rst  (i_Rst),
    .i_en   (1'b1),
    .i_sync (i_HSync),
    .o_fall (hfe)
  );

  // VSync is only looked at on line boundaries
  sync_fall_detect u_vs (
    .i_clk  (i_Clk),
    .i_rst  (i_Rst),
    .i_en   (hfe),
    .i_sync (i_VSync),
    .o_fall (vfe)
  );

  always_comb begin
    h_d = hfe ? '0 : sat_inc(h_q);
    v_d = v_q;
    if (vfe)      v_d = '0;
    else if (hfe) v_d = sat_inc(v_q);
    line_err  = hfe ? (h_q != H_LAST) : (h_d == H_END);
    frame_err = vfe ? (v_q != V_LAST) : (hfe && (v_d == V_END));
    err       = line_err | frame_err;
    h_act     = (h_d >= H_LO) && (h_d < H_HI);
    v_act     = (v_d >= V_LO) && (v_d < V_HI);
    valid_d   = (state_q == LOCKED) && h_act && v_act;
    x_d       = valid_d ? h_d - H_LO : '0;
    y_d       = valid_d ? v_d - V_LO : '0;
    fs_d      = valid_d && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      h_q     <= '0;
      v_q     <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
    end
  end

  // Errors are ignored while searching; the first edges are arbitrary
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= SEARCH;
      good_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        SEARCH: begin
          if (vfe) begin
            state_q <= TRACK;
            good_q  <= '0;
          end
        end
        TRACK: begin
          if (err) begin
            state_q <= SEARCH;
            err_q   <= 1'b1;
          end else if (vfe) begin
            good_q <= good_q + 8'd1;
            if (good_q + 8'd1 == LOCK_N) state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (err) begin
            state_q <= SEARCH;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_valid       = valid_q;
  assign o_locked      = (state_q == LOCKED);
  assign o_frame_start = fs_q;
  assign o_error       = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench: scaled-down VGA generator looped into the receiver,
// expected outputs queued per pixel and compared one clock later.
module tb_vga_sync_receiver;

  localparam int HS  = 4;
  localparam int HBP = 4;
  localparam int W   = 16;
  localparam int HT  = 32;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int HH  = 8;
  localparam int VT  = 16;
  localparam int HLO = HS + HBP;
  localparam int VLO = VS + VBP;

  typedef struct packed {
    logic        valid;
    logic        locked;
    logic        fs;
    logic        err;
    logic [11:0] x;
    logic [11:0] y;
  } obs_t;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b0;
  logic        i_HSync = 1'b1;
  logic        i_VSync = 1'b1;
  logic [11:0] o_x;
  logic [11:0] o_y;
  logic        o_valid;
  logic        o_locked;
  logic        o_frame_start;
  logic        o_error;

  int   nchk = 0;
  int   npass = 0;
  int   n_val = 0;
  int   n_fs = 0;
  int   n_err = 0;
  bit   exp_lock = 1'b0;
  obs_t sb[$];

  vga_sync_receiver #(
    .H_SYNC_WIDTH (HS),
    .H_BACK_PORCH (HBP),
    .WIDTH        (W),
    .H_TOTAL      (HT),
    .V_SYNC_WIDTH (VS),
    .V_BACK_PORCH (VBP),
    .HEIGHT       (HH),
    .V_TOTAL      (VT),
    .LOCK_FRAMES  (2)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Rst         (i_Rst),
    .i_HSync       (i_HSync),
    .i_VSync       (i_VSync),
    .o_x           (o_x),
    .o_y           (o_y),
    .o_valid       (o_valid),
    .o_locked      (o_locked),
    .o_frame_start (o_frame_start),
    .o_error       (o_error)
  );

  always #5 i_Clk = ~i_Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One generator pixel: drive syncs, queue expectation, compare after edge.
  task automatic pixel(input int hc, input int vc, input bit nl, input bit er);
    obs_t e;
    obs_t g;
    bit   act;
    i_HSync = (hc >= HS);
    i_VSync = (vc >= VS);
    act = exp_lock && hc >= HLO && hc < HLO + W && vc >= VLO && vc < VLO + HH;
    e.valid  = act;
    e.locked = nl;
    e.err    = er;
    e.x      = act ? 12'(hc - HLO) : 12'd0;
    e.y      = act ? 12'(vc - VLO) : 12'd0;
    e.fs     = act && hc == HLO && vc == VLO;
    exp_lock = nl;
    sb.push_back(e);
    @(posedge i_Clk);
    #1;
    g = {o_valid, o_locked, o_frame_start, o_error, o_x, o_y};
    e = sb.pop_front();
    chk($sformatf("pix v%0d h%0d", vc, hc), 32'(g), 32'(e));
    if (o_valid) n_val++;
    if (o_frame_start) n_fs++;
    if (o_error) n_err++;
  endtask

  task automatic run_frame(input int nlines, input int first_vc,
                           input int stop_vc, input int stop_hc,
                           input int short_vc, input int long_vc,
                           input bit start_lock, input bit start_err);
    int  len;
    bit  nl;
    bit  er;
    for (int vc = first_vc; vc < nlines; vc++) begin
      len = HT;
      if (vc == short_vc) len = HT - 1;
      if (vc == long_vc)  len = HT + 68;
      for (int hc = 0; hc < len; hc++) begin
        nl = exp_lock;
        er = 1'b0;
        if (hc == 0 && vc == 0 && first_vc == 0) begin
          nl = start_lock;
          er = start_err;
        end
        if (short_vc >= 0 && hc == 0 && vc == short_vc + 1) begin
          nl = 1'b0;
          er = 1'b1;
        end
        if (vc == long_vc && hc == HT) begin
          nl = 1'b0;
          er = 1'b1;
        end
        pixel(hc, vc, nl, er);
        if (vc == stop_vc && hc == stop_hc) return;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " o_valid"}, 32'(o_valid), 32'd0);
    chk({tag, " o_locked"}, 32'(o_locked), 32'd0);
    chk({tag, " o_frame_start"}, 32'(o_frame_start), 32'd0);
    chk({tag, " o_error"}, 32'(o_error), 32'd0);
    chk({tag, " o_x"}, 32'(o_x), 32'd0);
    chk({tag, " o_y"}, 32'(o_y), 32'd0);
  endtask

  initial begin
    #1;
    i_Rst = 1'b1;
    #2;
    chk_zero("reset");
    repeat (2) @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;

    // Acquire: lock visible after the third VSync edge
    run_frame(VT, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    run_frame(VT, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    chk("no valid before lock", 32'(n_val), 32'd0);
    n_val = 0;
    n_fs  = 0;
    run_frame(VT, 0, -1, -1, -1, -1, 1'b1, 1'b0);
    chk("locked frame valid count", 32'(n_val), 32'(W * HH));
    chk("locked frame start count", 32'(n_fs), 32'd1);
    chk("acquire error count", 32'(n_err), 32'd0);

    // Short line while locked
    n_err = 0;
    run_frame(VT, 0, -1, -1, 7, -1, 1'b1, 1'b0);
    chk("short line error count", 32'(n_err), 32'd1);
    n_val = 0;
    run_frame(VT, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    run_frame(VT, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    chk("no valid while relocking", 32'(n_val), 32'd0);
    run_frame(VT, 0, -1, -1, -1, -1, 1'b1, 1'b0);

    // HSync stuck high: line timeout while locked
    n_err = 0;
    run_frame(VT, 0, -1, -1, -1, 6, 1'b1, 1'b0);
    chk("timeout error count", 32'(n_err), 32'd1);
    run_frame(VT, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    run_frame(VT, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    run_frame(VT, 0, -1, -1, -1, -1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of an active line
    run_frame(VT, 0, 8, 12, -1, -1, 1'b1, 1'b0);
    #3;
    i_Rst = 1'b1;
    #1;
    chk_zero("async reset");
    repeat (3) @(posedge i_Clk);
    #1;
    chk_zero("held reset");
    i_Rst = 1'b0;
    exp_lock = 1'b0;
    n_err = 0;
    run_frame(VT, 9, -1, -1, -1, -1, 1'b0, 1'b0);
    run_frame(VT, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    run_frame(VT, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    run_frame(VT, 0, -1, -1, -1, -1, 1'b1, 1'b0);
    chk("post-reset error count", 32'(n_err), 32'd0);

    // Short frame while tracking
    run_frame(VT, 0, -1, -1, 10, -1, 1'b1, 1'b0);
    n_err = 0;
    run_frame(VT - 1, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    run_frame(VT, 0, -1, -1, -1, -1, 1'b0, 1'b1);
    chk("short frame error count", 32'(n_err), 32'd1);
    run_frame(VT, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    run_frame(VT, 0, -1, -1, -1, -1, 1'b0, 1'b0);
    n_fs = 0;
    run_frame(VT, 0, -1, -1, -1, -1, 1'b1, 1'b0);
    chk("relock frame start count", 32'(n_fs), 32'd1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
